// File: rtl/complex_accumulate_sequencer.sv
// Sequencer that streams complex operands through an external pipelined adder
// as a running accumulation, generating the start window and result strobe.
module complex_accumulate_sequencer #(
  parameter int ADD_LATENCY = 7,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               abort,
  input  logic [COUNT_W-1:0] length,
  input  logic               sub_mode,
  input  logic [63:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [63:0]        add_a,
  output logic [63:0]        add_b,
  output logic               add_op,
  output logic               add_ce,
  input  logic [63:0]        add_result,
  output logic               start,
  output logic               outsider15,
  output logic               busy,
  output logic               done,
  output logic [63:0]        sum,
  output logic               sum_valid
);

  typedef enum logic [2:0] {S_IDLE, S_FIRST, S_ISSUE, S_WAIT, S_DONE} state_t;

  // Strobe is registered, so it is armed one WAIT cycle before the result lands.
  localparam logic [7:0] WLAST = 8'(ADD_LATENCY - 1);

  state_t             state;
  logic [COUNT_W-1:0] remaining;
  logic [7:0]         wcnt;
  logic [63:0]        acc;
  logic               hs;

  assign in_ready = (state == S_FIRST) || (state == S_ISSUE);
  assign busy     = (state != S_IDLE);
  assign add_ce   = busy;
  assign hs       = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      remaining  <= '0;
      wcnt       <= '0;
      acc        <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_op     <= 1'b0;
      start      <= 1'b0;
      outsider15 <= 1'b0;
      done       <= 1'b0;
      sum        <= '0;
      sum_valid  <= 1'b0;
    end else begin
      done       <= 1'b0;
      outsider15 <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        start     <= 1'b0;
        sum_valid <= 1'b0;
        wcnt      <= '0;
      end else begin
        case (state)
          S_IDLE: if (go) begin
            start     <= 1'b1;
            sum_valid <= 1'b0;
            add_op    <= sub_mode;
            if (length == '0) begin
              sum       <= '0;
              sum_valid <= 1'b1;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              remaining <= length;
              state     <= S_FIRST;
            end
          end
          // First element bypasses the adder and seeds the accumulator.
          S_FIRST: if (hs) begin
            acc       <= in_data;
            remaining <= remaining - COUNT_W'(1);
            if (remaining == COUNT_W'(1)) begin
              sum       <= in_data;
              sum_valid <= 1'b1;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_ISSUE;
            end
          end
          S_ISSUE: if (hs) begin
            add_a <= acc;
            add_b <= in_data;
            wcnt  <= '0;
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (outsider15) begin
              acc       <= add_result;
              remaining <= remaining - COUNT_W'(1);
              if (remaining == COUNT_W'(1)) begin
                sum       <= add_result;
                sum_valid <= 1'b1;
                done      <= 1'b1;
                state     <= S_DONE;
              end else begin
                state <= S_ISSUE;
              end
            end else begin
              wcnt <= wcnt + 8'd1;
              if (wcnt == WLAST) outsider15 <= 1'b1;
            end
          end
          S_DONE: begin
            start <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_complex_accumulate_sequencer.sv
// Directed bench: behavioural latency-7 complex float adder plus vector table
// and hand sequences for abort and asynchronous reset.
module tb_complex_accumulate_sequencer;
  localparam int LAT    = 7;
  localparam int BUDGET = 200;

  logic        clk, rst_n, go, abort, sub_mode, in_valid;
  logic [15:0] length;
  logic [63:0] in_data, add_a, add_b, add_result, sum;
  logic        in_ready, add_op, add_ce, start, outsider15, busy, done, sum_valid;

  complex_accumulate_sequencer #(.ADD_LATENCY(LAT), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .length(length),
    .sub_mode(sub_mode), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_ce(add_ce),
    .add_result(add_result), .start(start), .outsider15(outsider15), .busy(busy),
    .done(done), .sum(sum), .sum_valid(sum_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [63:0] cadd(input logic [63:0] a, input logic [63:0] b, input logic op);
    real re, im;
    re = op ? f2r(a[63:32]) - f2r(b[63:32]) : f2r(a[63:32]) + f2r(b[63:32]);
    im = op ? f2r(a[31:0])  - f2r(b[31:0])  : f2r(a[31:0])  + f2r(b[31:0]);
    return {r2f(re), r2f(im)};
  endfunction

  // Adder model: result valid LAT cycles after the operands are presented.
  logic [63:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= cadd(add_a, add_b, add_op);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign add_result = pipe[LAT-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          n;
    bit          sub;
    logic [63:0] d0, d1, d2;
    int          stall;
    bit          hold;
    logic [63:0] es;
    int          edone;
    int          eosn;
    int          eos1;
  } vec_t;

  vec_t vt [5];

  task automatic run(input vec_t v, output int dcyc, output logic [63:0] s, output int osn,
                     output int os1, output bit op_ok, output bit rdy, output bit sv_ok,
                     output bit st_ok);
    int idx, stl;
    logic [63:0] d [3];
    d = '{v.d0, v.d1, v.d2};
    idx = 0; stl = v.stall;
    dcyc = -1; s = '0; osn = 0; os1 = -1; op_ok = 1; rdy = 0; sv_ok = 0; st_ok = 1;
    @(negedge clk);
    go = 1'b1; length = 16'(v.n); sub_mode = v.sub; in_valid = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      go = v.hold;
      if (outsider15) begin osn++; if (os1 < 0) os1 = k; end
      if (in_ready) rdy = 1;
      if (busy && add_op !== v.sub) op_ok = 0;
      if (busy && !start) st_ok = 0;
      if (done) begin
        dcyc = k; s = sum; sv_ok = sum_valid; in_valid = 1'b0; go = 1'b0;
        break;
      end
      if (in_ready && idx < v.n) begin
        if (stl > 0) begin in_valid = 1'b0; stl--; end
        else begin in_valid = 1'b1; in_data = d[idx]; idx++; stl = v.stall; end
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic apply(input string tag, input vec_t v);
    int dcyc, osn, os1;
    logic [63:0] s;
    bit op_ok, rdy, sv_ok, st_ok;
    run(v, dcyc, s, osn, os1, op_ok, rdy, sv_ok, st_ok);
    chk({tag, " done_cycle"}, 64'(dcyc), 64'(v.edone));
    chk({tag, " sum"}, s, v.es);
    chk({tag, " outsider15_count"}, 64'(osn), 64'(v.eosn));
    chk({tag, " outsider15_first"}, 64'(os1), 64'(v.eos1));
    chk({tag, " add_op_busy"}, 64'(op_ok), 64'd1);
    chk({tag, " in_ready_seen"}, 64'(rdy), 64'(v.n >= 1));
    chk({tag, " sum_valid_at_done"}, 64'(sv_ok), 64'd1);
    chk({tag, " start_while_busy"}, 64'(st_ok), 64'd1);
    @(negedge clk);
    chk({tag, " start_after"}, 64'(start), 64'd0);
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
    chk({tag, " sum_hold"}, sum, v.es);
    chk({tag, " sum_valid_hold"}, 64'(sum_valid), 64'd1);
  endtask

  localparam logic [63:0] C12 = 64'h3F800000_40000000;
  localparam logic [63:0] C36 = 64'h40400000_40C00000;
  localparam logic [63:0] C55 = 64'h40A00000_40A00000;
  localparam logic [63:0] C21 = 64'h40000000_3F800000;
  localparam logic [63:0] C34 = 64'h40400000_40800000;
  localparam logic [63:0] CX  = 64'h12345678_9ABCDEF0;

  initial begin
    bit bad;
    vt[0] = '{3, 1'b0, C12, C12, C12, 0, 1'b0, C36, 20, 2, 10};
    vt[1] = '{2, 1'b1, C55, C21, 64'd0, 0, 1'b0, C34, 11, 1, 10};
    vt[2] = '{1, 1'b0, CX, 64'd0, 64'd0, 0, 1'b0, CX, 2, 0, -1};
    vt[3] = '{0, 1'b0, 64'd0, 64'd0, 64'd0, 0, 1'b0, 64'd0, 1, 0, -1};
    vt[4] = '{3, 1'b0, C12, C12, C12, 4, 1'b0, C36, 32, 2, 18};

    go = 0; abort = 0; sub_mode = 0; in_valid = 0; length = '0; in_data = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset ctl", 64'({in_ready, add_op, add_ce, start, outsider15, busy, done, sum_valid}), 64'd0);
    chk("reset sum", sum, 64'd0);
    chk("reset add_a", add_a, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) apply($sformatf("vec%0d", i), vt[i]);

    // Abort one cycle ahead of the first result strobe.
    @(negedge clk);
    go = 1'b1; length = 16'd3; sub_mode = 1'b0;
    bad = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      go = 1'b0;
      if (outsider15 || done) bad = 1;
      in_valid = in_ready; in_data = C12;
      if (k == 9) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    chk("abort early_strobe", 64'(bad), 64'd0);
    chk("abort idle", 64'({busy, add_ce, start, outsider15, done, sum_valid}), 64'd0);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (outsider15 || done || busy) bad = 1;
    end
    chk("abort quiet", 64'(bad), 64'd0);
    apply("post_abort", vt[1]);

    // Asynchronous reset in the middle of WAIT.
    @(negedge clk);
    go = 1'b1; length = 16'd2; sub_mode = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      go = 1'b0;
      in_valid = in_ready; in_data = C55;
    end
    in_valid = 1'b0;
    chk("pre_reset add_a", add_a, C55);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset ctl", 64'({in_ready, add_op, add_ce, start, outsider15, busy, done, sum_valid}), 64'd0);
    chk("async_reset add_a", add_a, 64'd0);
    chk("async_reset add_b", add_b, 64'd0);
    chk("async_reset sum", sum, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // go held high for the whole busy run must not retrigger or disturb it.
    vt[0].hold = 1'b1;
    apply("go_while_busy", vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
